// File: rtl/gs_wr_agen_pkg.sv
// gs_wr_agen_pkg
// Shared constants for the filtered-sample write address generator.
//   ST_*   : controller state encoding (IDLE / RUN / DRAIN)
//   PASS_* : pass encoding (row pass first, then column pass)
package gs_wr_agen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic PASS_ROW = 1'b0;
    localparam logic PASS_COL = 1'b1;

endpackage

// File: rtl/gs_out_stage.sv
// gs_out_stage
// One-entry valid/ready register. The payload is captured when load is
// high and held until the consumer takes it (pop). The caller only loads
// when the entry is empty or being popped in the same cycle, so a held
// payload never changes under a stall.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear, drops any held entry
//   load, d    : write a new entry
//   pop        : consumer accepts the current entry
//   valid, q   : entry present / entry payload
module gs_out_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] q
);

    // Load wins over pop so a back-to-back stream sustains one entry per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gs_wr_agen.sv
// gs_wr_agen
// Write address generator for a separable 2-D filter. Filtered samples
// arrive as a stream; the first SKIP samples of each line are pipeline
// fill and are consumed but dropped. Kept samples are written to a
// 2^LOG2N x 2^LOG2N frame memory, row-major on pass 0 and transposed
// (column-major) on pass 1.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   start                         : arms a frame when idle
//   clr                           : synchronous abort back to idle
//   in_valid, in_data, in_ready   : filtered sample stream
//   out_valid, out_addr, out_data,
//   out_ready                     : memory write port
//   busy                          : frame in progress
//   pass_idx                      : current pass (0 row, 1 column)
//   done                          : final write of the frame accepted
module gs_wr_agen
    import gs_wr_agen_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LOG2N = 8,
    parameter int SKIP  = 4,
    parameter int NPASS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [2*LOG2N-1:0]   out_addr,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 pass_idx,
    output logic                 done
);

    localparam int AW = 2 * LOG2N;
    localparam int XW = LOG2N + 1;
    localparam logic signed [XW-1:0] X_INIT = XW'(-SKIP);
    localparam logic signed [XW-1:0] X_MAX  = XW'((1 << LOG2N) - 1);
    localparam logic [LOG2N-1:0]     Y_MAX  = '1;
    localparam logic                 P_LAST = 1'(NPASS - 1);

    logic [1:0]              state;
    logic signed [XW-1:0]    x;
    logic [LOG2N-1:0]        y;
    logic                    p;

    logic                    accept;
    logic                    x_wrap;
    logic                    last_beat;
    logic                    keep;
    logic [AW-1:0]           wr_addr;
    logic                    out_last;
    logic [AW-1:0]           stage_addr;
    logic [DW-1:0]           stage_data;

    // The counters only move on accepted beats, so a stalled or gappy
    // stream never shifts the address pattern.
    assign accept    = in_valid && in_ready;
    assign x_wrap    = (x == X_MAX);
    assign last_beat = x_wrap && (y == Y_MAX) && (p == P_LAST);
    // Negative x marks the filter fill samples at the start of each line.
    assign keep      = accept && !x[XW-1];
    assign wr_addr   = (p == PASS_COL) ? {x[LOG2N-1:0], y} : {y, x[LOG2N-1:0]};

    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready) && !clr;
    assign busy      = (state != ST_IDLE);
    assign pass_idx  = p;
    // The last-write flag travels with the entry so done lines up with the
    // handshake of that exact write, however long it stalls.
    assign done      = out_valid && out_ready && out_last && !clr;
    assign out_addr  = stage_addr;
    assign out_data  = stage_data;

    // Controller: the frame ends once the final beat has been accepted and
    // its write (if any) has left the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (clr) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_RUN;
                ST_RUN:   if (accept && last_beat) state <= ST_DRAIN;
                ST_DRAIN: if (!out_valid || out_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Position counters. After the last beat they wrap naturally back to
    // their initial values, ready for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= X_INIT;
            y <= '0;
            p <= PASS_ROW;
        end else if (clr) begin
            x <= X_INIT;
            y <= '0;
            p <= PASS_ROW;
        end else if (accept) begin
            if (x_wrap) begin
                x <= X_INIT;
                if (y == Y_MAX) begin
                    y <= '0;
                    p <= (p == P_LAST) ? PASS_ROW : PASS_COL;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    gs_out_stage #(
        .W (AW + DW + 1)
    ) u_out_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .load  (keep),
        .d     ({last_beat, wr_addr, in_data}),
        .pop   (out_ready),
        .valid (out_valid),
        .q     ({out_last, stage_addr, stage_data})
    );

endmodule

// File: tb/tb_gs_wr_agen.sv
// tb_gs_wr_agen
// Scoreboard bench for gs_wr_agen. Instance A: LOG2N=2, SKIP=2, NPASS=2.
// Instance B: LOG2N=2, SKIP=0, NPASS=1. Expected writes are queued when a
// test is issued; per-instance monitors pop and compare on every write.
module tb_gs_wr_agen;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       start_a, clr_a, in_valid_a, in_ready_a;
    logic [7:0] in_data_a, out_data_a;
    logic       out_valid_a, out_ready_a, busy_a, pass_idx_a, done_a;
    logic [3:0] out_addr_a;

    logic       start_b, clr_b, in_valid_b, in_ready_b;
    logic [7:0] in_data_b, out_data_b;
    logic       out_valid_b, out_ready_b, busy_b, pass_idx_b, done_b;
    logic [3:0] out_addr_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   tests;
    int   errors;
    int   done_cnt_a;
    int   done_cnt_b;
    logic stall_en;

    // Pass 0 is row-major, pass 1 is the transposed (column-major) order.
    logic [3:0] addr_tab [32] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
        4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15
    };

    gs_wr_agen #(.DW(8), .LOG2N(2), .SKIP(2), .NPASS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .clr(clr_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_addr(out_addr_a), .out_data(out_data_a),
        .out_ready(out_ready_a), .busy(busy_a), .pass_idx(pass_idx_a), .done(done_a)
    );

    gs_wr_agen #(.DW(8), .LOG2N(2), .SKIP(0), .NPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .clr(clr_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_addr(out_addr_b), .out_data(out_data_b),
        .out_ready(out_ready_b), .busy(busy_b), .pass_idx(pass_idx_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Write w of a full A frame: beat index = pass*24 + line*6 + SKIP + col,
    // and the bench drives data 0x40 + beat index.
    task automatic push_frame_a(input int nwrites, input logic last_ok);
        exp_t e;
        for (int w = 0; w < nwrites; w++) begin
            e.addr = addr_tab[w];
            e.data = 8'(8'h40 + (w / 16) * 24 + ((w % 16) / 4) * 6 + 2 + (w % 4));
            e.last = last_ok && (w == 31);
            exp_a.push_back(e);
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        #1;
        check_output("A busy after start", busy_a, 1);
    endtask

    // Drives n beats; start is re-pulsed while beat `poke` is presented.
    task automatic apply_stimulus(input int n, input int poke);
        int k;
        int c;
        k = 0;
        c = 0;
        while (k < n && c < 2000) begin
            @(negedge clk);
            in_valid_a = 1'b1;
            in_data_a  = 8'(8'h40 + k);
            start_a    = (k == poke);
            #1;
            if (in_ready_a) k++;
            c++;
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        start_a    = 1'b0;
        check_output("A beats accepted", k, n);
    endtask

    task automatic wait_idle_a();
        int c;
        c = 0;
        while (busy_a && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check_output("A returns idle", busy_a, 0);
        check_output("A all writes seen", exp_a.size(), 0);
        check_output("A done count", done_cnt_a, 1);
        done_cnt_a = 0;
    endtask

    // Random out_ready with roughly 30% stall cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_en) out_ready_a = ($urandom_range(0, 99) >= 30);
        end
    end

    // Monitor A: scoreboard compare plus hold-stable check across stalls.
    initial begin
        exp_t e;
        logic       prev_stall;
        logic [3:0] prev_addr;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n || clr_a) begin
                prev_stall = 1'b0;
                continue;
            end
            if (out_valid_a && out_ready_a) begin
                check_output("A write expected", int'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    check_output("A out_addr", out_addr_a, e.addr);
                    check_output("A out_data", out_data_a, e.data);
                    check_output("A done on write", done_a, e.last);
                end
                if (done_a) done_cnt_a++;
            end else if (done_a) begin
                check_output("A done without write", done_a, 0);
            end
            if (prev_stall) begin
                check_output("A stall out_valid held", out_valid_a, 1);
                check_output("A stall out_addr held", out_addr_a, prev_addr);
                check_output("A stall out_data held", out_data_a, prev_data);
            end
            prev_stall = out_valid_a && !out_ready_a;
            prev_addr  = out_addr_a;
            prev_data  = out_data_a;
        end
    end

    // Monitor B.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) continue;
            if (out_valid_b && out_ready_b) begin
                check_output("B write expected", int'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    check_output("B out_addr", out_addr_b, e.addr);
                    check_output("B out_data", out_data_b, e.data);
                    check_output("B done on write", done_b, e.last);
                end
                if (done_b) done_cnt_b++;
            end else if (done_b) begin
                check_output("B done without write", done_b, 0);
            end
        end
    end

    initial begin
        exp_t e;
        int   k;
        int   c;
        tests = 0; errors = 0; done_cnt_a = 0; done_cnt_b = 0;
        stall_en = 1'b0;
        rst_n = 1'b0;
        start_a = 0; clr_a = 0; in_valid_a = 0; in_data_a = '0; out_ready_a = 1'b1;
        start_b = 0; clr_b = 0; in_valid_b = 0; in_data_b = '0; out_ready_b = 1'b1;

        // Reset state.
        #3;
        check_output("reset busy", busy_a, 0);
        check_output("reset out_valid", out_valid_a, 0);
        check_output("reset out_addr", out_addr_a, 0);
        check_output("reset out_data", out_data_a, 0);
        check_output("reset done", done_a, 0);
        check_output("reset in_ready", in_ready_a, 0);
        check_output("reset pass_idx", pass_idx_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full two-pass frame, continuous flow.
        push_frame_a(32, 1'b1);
        pulse_start_a();
        apply_stimulus(48, -1);
        wait_idle_a();

        // Same frame with a stalling write port.
        stall_en = 1'b1;
        push_frame_a(32, 1'b1);
        pulse_start_a();
        apply_stimulus(48, -1);
        wait_idle_a();
        stall_en = 1'b0;
        @(negedge clk);
        out_ready_a = 1'b1;

        // Abort after 10 beats; the write held at abort time is dropped.
        push_frame_a(5, 1'b0);
        pulse_start_a();
        apply_stimulus(10, -1);
        clr_a = 1'b1;
        out_ready_a = 1'b0;
        @(negedge clk);
        clr_a = 1'b0;
        out_ready_a = 1'b1;
        #1;
        check_output("clr busy", busy_a, 0);
        check_output("clr out_valid", out_valid_a, 0);
        check_output("clr writes seen", exp_a.size(), 0);
        check_output("clr no done", done_cnt_a, 0);
        push_frame_a(32, 1'b1);
        pulse_start_a();
        apply_stimulus(48, -1);
        wait_idle_a();

        // Start re-pulsed mid-frame must not disturb anything.
        push_frame_a(32, 1'b1);
        pulse_start_a();
        apply_stimulus(48, 20);
        wait_idle_a();

        // Single pass, no skip.
        for (int i = 0; i < 16; i++) begin
            e.addr = 4'(i);
            e.data = 8'(8'h80 + i);
            e.last = (i == 15);
            exp_b.push_back(e);
        end
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        c = 0;
        while (k < 16 && c < 200) begin
            @(negedge clk);
            in_valid_b = 1'b1;
            in_data_b  = 8'(8'h80 + k);
            #1;
            if (in_ready_b) k++;
            c++;
        end
        @(negedge clk);
        in_valid_b = 1'b0;
        check_output("B beats accepted", k, 16);
        c = 0;
        while (busy_b && c < 100) begin
            @(negedge clk);
            c++;
        end
        check_output("B returns idle", busy_b, 0);
        check_output("B all writes seen", exp_b.size(), 0);
        check_output("B done count", done_cnt_b, 1);

        // Asynchronous reset mid-frame with a write pending.
        push_frame_a(2, 1'b0);
        pulse_start_a();
        apply_stimulus(5, -1);
        out_ready_a = 1'b0;
        #1;
        check_output("A pending before reset", out_valid_a, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async reset out_valid", out_valid_a, 0);
        check_output("async reset out_addr", out_addr_a, 0);
        check_output("async reset out_data", out_data_a, 0);
        check_output("async reset busy", busy_a, 0);
        check_output("async reset done", done_a, 0);
        check_output("async reset in_ready", in_ready_a, 0);
        check_output("async reset writes seen", exp_a.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_a = 1'b1;
        repeat (2) @(negedge clk);
        check_output("no restart without start", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
